pet_needs_responder: RTL and testbench

Responder side of the button hold-request handshake. The button/mode block issues one-cycle "5-second hold" request pulses for feeding and medicine. This block acknowledges each request with an Activo pulse of fixed length and then raises the corresponding 2-bit need level. It also decays both levels over time and flags when any need is exhausted. Its level outputs feed the pet state machine and the LED/display path.

---
 rtl/pet_needs_responder.sv | 114 +++++++++++
 tb/tb_pet_needs_responder.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/pet_needs_responder.sv
// rtl/pet_needs_responder.sv - hold-request responder: service pulses, need levels, decay and alert
module pet_needs_responder #(
    parameter int unsigned DECAY_CYCLES   = 500_000_000,
    parameter int unsigned SERVICE_CYCLES = 100_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_comida,
    input  logic       req_medicina,
    output logic       Activo_Comida,
    output logic       Activo_Medicina,
    output logic [1:0] Nivel_Comida,
    output logic [1:0] Nivel_Medicina,
    output logic       alerta,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE          = 2'd0,
        SERV_COMIDA   = 2'd1,
        SERV_MEDICINA = 2'd2
    } state_t;

    localparam logic [31:0] DECAY_LAST   = DECAY_CYCLES - 1;
    localparam logic [31:0] SERVICE_LAST = SERVICE_CYCLES - 1;

    state_t      state;
    state_t      state_next;
    logic [31:0] svc_cnt;
    logic [31:0] decay_cnt;
    logic        svc_done;
    logic        decay_tick;
    logic        inc_comida;
    logic        inc_medicina;

    assign svc_done     = (state != IDLE) && (svc_cnt == 32'd0);
    assign decay_tick   = (decay_cnt == DECAY_LAST);
    assign inc_comida   = svc_done && (state == SERV_COMIDA);
    assign inc_medicina = svc_done && (state == SERV_MEDICINA);

    // Comida has priority; a simultaneous medicina request is dropped, not queued.
    always_comb begin
        state_next      = state;
        Activo_Comida   = 1'b0;
        Activo_Medicina = 1'b0;
        busy            = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_comida)
                    state_next = SERV_COMIDA;
                else if (req_medicina)
                    state_next = SERV_MEDICINA;
            end
            SERV_COMIDA: begin
                Activo_Comida = 1'b1;
                busy          = 1'b1;
                if (svc_cnt == 32'd0)
                    state_next = IDLE;
            end
            SERV_MEDICINA: begin
                Activo_Medicina = 1'b1;
                busy            = 1'b1;
                if (svc_cnt == 32'd0)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            svc_cnt <= 32'd0;
        end else begin
            state <= state_next;
            if (state == IDLE && state_next != IDLE)
                svc_cnt <= SERVICE_LAST;
            else if (svc_cnt != 32'd0)
                svc_cnt <= svc_cnt - 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset)
            decay_cnt <= 32'd0;
        else if (decay_tick)
            decay_cnt <= 32'd0;
        else
            decay_cnt <= decay_cnt + 32'd1;
    end

    // A completing service on a level overrides a same-cycle decay of that level.
    function automatic logic [1:0] level_step(input logic [1:0] lvl, input logic inc,
                                              input logic dec);
        if (inc)
            return (lvl == 2'd3) ? 2'd3 : lvl + 2'd1;
        if (dec && lvl != 2'd0)
            return lvl - 2'd1;
        return lvl;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) begin
            Nivel_Comida   <= 2'd3;
            Nivel_Medicina <= 2'd3;
        end else begin
            Nivel_Comida   <= level_step(Nivel_Comida, inc_comida, decay_tick);
            Nivel_Medicina <= level_step(Nivel_Medicina, inc_medicina, decay_tick);
        end
    end

    assign alerta = (Nivel_Comida == 2'd0) || (Nivel_Medicina == 2'd0);

endmodule

// File: tb/tb_pet_needs_responder.sv
// tb/tb_pet_needs_responder.sv - directed vector bench for pet_needs_responder
module tb_pet_needs_responder;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       req_comida = 1'b0;
    logic       req_medicina = 1'b0;
    logic       Activo_Comida;
    logic       Activo_Medicina;
    logic [1:0] Nivel_Comida;
    logic [1:0] Nivel_Medicina;
    logic       alerta;
    logic       busy;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pet_needs_responder #(
        .DECAY_CYCLES  (20),
        .SERVICE_CYCLES(4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req_comida     (req_comida),
        .req_medicina   (req_medicina),
        .Activo_Comida  (Activo_Comida),
        .Activo_Medicina(Activo_Medicina),
        .Nivel_Comida   (Nivel_Comida),
        .Nivel_Medicina (Nivel_Medicina),
        .alerta         (alerta),
        .busy           (busy)
    );

    typedef struct {
        int         cyc;
        logic       rst;
        logic       rc;
        logic       rm;
        logic       ac;
        logic       am;
        logic [1:0] nc;
        logic [1:0] nm;
        logic       al;
        logic       bz;
    } vec_t;

    vec_t tbl[$];

    task automatic row(input int cyc, input logic rst, input logic rc, input logic rm,
                       input logic ac, input logic am, input logic [1:0] nc,
                       input logic [1:0] nm, input logic al, input logic bz);
        vec_t v;
        v.cyc = cyc; v.rst = rst; v.rc = rc; v.rm = rm;
        v.ac = ac; v.am = am; v.nc = nc; v.nm = nm; v.al = al; v.bz = bz;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got {ac,am,nc,nm,al,bz}=%b expected %b", name, got, exp);
        end
    endtask

    initial begin
        int high_cnt;
        logic busy_ok;

        // t = edges with reset high since the last reset; decay ticks at t = 20, 40, 60, ...
        //   cyc rst rc rm  ac am nc nm al bz
        row(3,  0, 0, 0,  0, 0, 3, 3, 0, 0);   // reset held, no decay
        row(19, 1, 0, 0,  0, 0, 3, 3, 0, 0);   // t=19
        row(1,  1, 0, 0,  0, 0, 2, 2, 0, 0);   // t=20 first tick
        row(20, 1, 0, 0,  0, 0, 1, 1, 0, 0);   // t=40
        row(19, 1, 0, 0,  0, 0, 1, 1, 0, 0);   // t=59
        row(1,  1, 0, 0,  0, 0, 0, 0, 1, 0);   // t=60 empty, alerta
        row(20, 1, 0, 0,  0, 0, 0, 0, 1, 0);   // t=80 saturates at 0
        row(2,  0, 0, 0,  0, 0, 3, 3, 0, 0);   // reset again
        row(40, 1, 0, 0,  0, 0, 1, 1, 0, 0);   // t=40
        row(1,  1, 1, 0,  1, 0, 1, 1, 0, 1);   // t=41 feed request accepted
        row(1,  1, 0, 0,  1, 0, 1, 1, 0, 1);   // t=42
        row(1,  1, 1, 0,  1, 0, 1, 1, 0, 1);   // t=43 mid-service request ignored
        row(1,  1, 0, 0,  1, 0, 1, 1, 0, 1);   // t=44 fourth Activo cycle
        row(1,  1, 0, 0,  0, 0, 2, 1, 0, 0);   // t=45 Activo falls, level +1
        row(5,  1, 0, 0,  0, 0, 2, 1, 0, 0);   // t=50 no second service
        row(5,  1, 0, 0,  0, 0, 2, 1, 0, 0);   // t=55
        row(1,  1, 1, 0,  1, 0, 2, 1, 0, 1);   // t=56 completes on tick edge 60
        row(3,  1, 0, 0,  1, 0, 2, 1, 0, 1);   // t=59
        row(1,  1, 0, 0,  0, 0, 3, 0, 1, 0);   // t=60 collision: comida +1, medicina -1
        row(1,  1, 1, 1,  1, 0, 3, 0, 1, 1);   // t=61 both requests: comida wins
        row(4,  1, 0, 0,  0, 0, 3, 0, 1, 0);   // t=65 medicina unchanged
        row(1,  1, 0, 1,  0, 1, 3, 0, 1, 1);   // t=66 medicine request
        row(4,  1, 0, 0,  0, 0, 3, 1, 0, 0);   // t=70 medicina +1
        row(1,  1, 0, 1,  0, 1, 3, 1, 0, 1);   // t=71
        row(1,  1, 0, 0,  0, 1, 3, 1, 0, 1);   // t=72 second Activo cycle
        row(1,  0, 0, 0,  0, 0, 3, 3, 0, 0);   // reset aborts service
        row(4,  1, 0, 0,  0, 0, 3, 3, 0, 0);   // t=4 no late increment
        row(15, 1, 0, 0,  0, 0, 3, 3, 0, 0);   // t=19 decay counter was cleared
        row(1,  1, 0, 0,  0, 0, 2, 2, 0, 0);   // t=20

        for (int i = 0; i < tbl.size(); i++) begin
            reset        = tbl[i].rst;
            req_comida   = tbl[i].rc;
            req_medicina = tbl[i].rm;
            @(posedge clk);
            #1;
            req_comida   = 1'b0;
            req_medicina = 1'b0;
            if (tbl[i].cyc > 1)
                repeat (tbl[i].cyc - 1) begin
                    @(posedge clk);
                    #1;
                end
            check($sformatf("row%0d", i),
                  {Activo_Comida, Activo_Medicina, Nivel_Comida, Nivel_Medicina, alerta, busy},
                  {tbl[i].ac, tbl[i].am, tbl[i].nc, tbl[i].nm, tbl[i].al, tbl[i].bz});
        end

        // Medicine pulse width measured cycle by cycle (t=21, completes at t=25).
        req_medicina = 1'b1;
        @(posedge clk);
        #1;
        req_medicina = 1'b0;
        high_cnt = 0;
        busy_ok  = 1'b1;
        for (int c = 0; c < 20 && Activo_Medicina; c++) begin
            high_cnt++;
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clk);
            #1;
        end
        vectors++;
        if (high_cnt != 4) begin
            miscompares++;
            $display("FAIL med_width: got %0d cycles expected 4", high_cnt);
        end
        vectors++;
        if (!busy_ok || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL med_busy: got busy_ok=%b busy=%b expected 1 and 0", busy_ok, busy);
        end
        check("med_done", {Activo_Comida, Activo_Medicina, Nivel_Comida, Nivel_Medicina, alerta, busy},
              {1'b0, 1'b0, 2'd2, 2'd3, 1'b0, 1'b0});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
